// File: rtl/yari_mem_arbiter.sv
// Shares the external memory port between dmem (read/write) and imem (read-only).
// Optional performance counters are enabled by defining YARI_ARB_PERF_EN.
module yari_mem_arbiter #(
   parameter logic [1:0] ID_DC           = 2'd1,
   parameter logic [1:0] ID_IC           = 2'd2,
   parameter int         STARVE_LIMIT    = 16,
   parameter int         MAX_OUTSTANDING = 4
) (
   input  logic        clock,
   input  logic        rst_n,

   output logic        dmem_waitrequest,
   input  logic [29:0] dmem_address,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [31:0] dmem_writedata,
   input  logic [3:0]  dmem_writedatamask,
   output logic [31:0] dmem_readdata,
   output logic        dmem_readdatavalid,

   output logic        imem_waitrequest,
   input  logic [29:0] imem_address,
   input  logic        imem_read,
   output logic [31:0] imem_readdata,
   output logic        imem_readdatavalid,

   input  logic        mem_waitrequest,
   output logic [1:0]  mem_id,
   output logic [29:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_writedatamask,
   input  logic [31:0] mem_readdata,
   input  logic [1:0]  mem_readdataid
`ifdef YARI_ARB_PERF_EN
   ,
   output logic [31:0] perf_arb_imem_blocked,
   output logic [31:0] perf_arb_dmem_blocked,
   output logic [31:0] perf_arb_outstanding_full
`endif
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
   localparam logic [3:0] OUT_MAX    = 4'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCK_D = 2'd1,
      ST_LOCK_I = 2'd2
   } arb_state_e;

   arb_state_e  state_r;
   logic [7:0]  starve_cnt_r;
   logic [3:0]  d_out_r;
   logic [3:0]  i_out_r;

   logic        resp_d_s;
   logic        resp_i_s;
   logic [3:0]  d_out_eff_s;
   logic [3:0]  i_out_eff_s;
   logic        d_strobe_s;
   logic        d_eligible_s;
   logic        i_eligible_s;
   logic        owner_d_s;
   logic        owner_i_s;
   logic        d_acc_s;
   logic        d_rd_acc_s;
   logic        i_acc_s;

   // Saturating outstanding-read counter update; simultaneous inc/dec cancels.
   function automatic logic [3:0] out_next(input logic [3:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
      logic [3:0] nxt;
      case ({inc, dec})
         2'b10:   nxt = cnt + 4'd1;
         2'b01:   nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
         default: nxt = cnt;
      endcase
      return nxt;
   endfunction

   assign resp_d_s   = (mem_readdataid == ID_DC);
   assign resp_i_s   = (mem_readdataid == ID_IC);
   assign d_strobe_s = dmem_read | dmem_write;

   // A response retiring in this cycle frees its slot immediately.
   assign d_out_eff_s = d_out_r - {3'd0, resp_d_s & (d_out_r != 4'd0)};
   assign i_out_eff_s = i_out_r - {3'd0, resp_i_s & (i_out_r != 4'd0)};

   assign d_eligible_s = (dmem_read & (d_out_eff_s < OUT_MAX)) | dmem_write;
   assign i_eligible_s = imem_read & (i_out_eff_s < OUT_MAX);

   // Owner selection: locks force the owner, otherwise dmem priority with starvation override.
   always_comb begin
      owner_d_s = 1'b0;
      owner_i_s = 1'b0;
      case (state_r)
         ST_LOCK_D: owner_d_s = 1'b1;
         ST_LOCK_I: owner_i_s = 1'b1;
         ST_IDLE: begin
            if (i_eligible_s && ((starve_cnt_r == STARVE_MAX) || !d_eligible_s)) begin
               owner_i_s = 1'b1;
            end else if (d_eligible_s) begin
               owner_d_s = 1'b1;
            end else begin
               owner_d_s = 1'b0;
            end
         end
         default: begin
            owner_d_s = 1'b0;
            owner_i_s = 1'b0;
         end
      endcase
   end

   // Memory-side mux; everything is held quiet while reset is asserted.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = imem_address;
      mem_id      = ID_IC;
      if (!rst_n) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end else if (owner_d_s) begin
         mem_read    = dmem_read & ~dmem_write;
         mem_write   = dmem_write;
         mem_address = dmem_address;
         mem_id      = ID_DC;
      end else if (owner_i_s) begin
         mem_read    = imem_read;
         mem_address = imem_address;
         mem_id      = ID_IC;
      end else begin
         mem_id = ID_IC;
      end
   end

   assign mem_writedata     = dmem_writedata;
   assign mem_writedatamask = dmem_writedatamask;

   assign dmem_waitrequest = ~(rst_n & owner_d_s) | mem_waitrequest;
   assign imem_waitrequest = ~(rst_n & owner_i_s) | mem_waitrequest;

   assign dmem_readdata      = mem_readdata;
   assign imem_readdata      = mem_readdata;
   assign dmem_readdatavalid = rst_n & resp_d_s;
   assign imem_readdatavalid = rst_n & resp_i_s;

   assign d_acc_s    = rst_n & owner_d_s & d_strobe_s & ~mem_waitrequest;
   assign d_rd_acc_s = d_acc_s & dmem_read & ~dmem_write;
   assign i_acc_s    = rst_n & owner_i_s & imem_read & ~mem_waitrequest;

   // Grant FSM, starvation counter and outstanding-read counters.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         starve_cnt_r <= 8'd0;
         d_out_r      <= 4'd0;
         i_out_r      <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (owner_d_s && d_strobe_s && mem_waitrequest) begin
                  state_r <= ST_LOCK_D;
               end else if (owner_i_s && imem_read && mem_waitrequest) begin
                  state_r <= ST_LOCK_I;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOCK_D: state_r <= (d_strobe_s && mem_waitrequest) ? ST_LOCK_D : ST_IDLE;
            ST_LOCK_I: state_r <= (imem_read && mem_waitrequest) ? ST_LOCK_I : ST_IDLE;
            default:   state_r <= ST_IDLE;
         endcase

         if (imem_read && !i_acc_s) begin
            starve_cnt_r <= (starve_cnt_r == STARVE_MAX) ? starve_cnt_r : starve_cnt_r + 8'd1;
         end else begin
            starve_cnt_r <= 8'd0;
         end

         d_out_r <= out_next(d_out_r, d_rd_acc_s, resp_d_s);
         i_out_r <= out_next(i_out_r, i_acc_s, resp_i_s);
      end
   end

`ifdef YARI_ARB_PERF_EN
   // Free-running contention counters, wrapping at 2^32.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         perf_arb_imem_blocked     <= 32'd0;
         perf_arb_dmem_blocked     <= 32'd0;
         perf_arb_outstanding_full <= 32'd0;
      end else begin
         if (imem_read && !owner_i_s) begin
            perf_arb_imem_blocked <= perf_arb_imem_blocked + 32'd1;
         end else begin
            perf_arb_imem_blocked <= perf_arb_imem_blocked;
         end
         if (d_strobe_s && !owner_d_s) begin
            perf_arb_dmem_blocked <= perf_arb_dmem_blocked + 32'd1;
         end else begin
            perf_arb_dmem_blocked <= perf_arb_dmem_blocked;
         end
         if ((dmem_read && (d_out_r == OUT_MAX)) || (imem_read && (i_out_r == OUT_MAX))) begin
            perf_arb_outstanding_full <= perf_arb_outstanding_full + 32'd1;
         end else begin
            perf_arb_outstanding_full <= perf_arb_outstanding_full;
         end
      end
   end
`endif

endmodule

// File: tb/tb_yari_mem_arbiter.sv
// Directed self-checking bench for yari_mem_arbiter (default parameters).
module tb_yari_mem_arbiter;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        dmem_waitrequest;
   logic [29:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_writedata;
   logic [3:0]  dmem_writedatamask;
   logic [31:0] dmem_readdata;
   logic        dmem_readdatavalid;
   logic        imem_waitrequest;
   logic [29:0] imem_address;
   logic        imem_read;
   logic [31:0] imem_readdata;
   logic        imem_readdatavalid;
   logic        mem_waitrequest;
   logic [1:0]  mem_id;
   logic [29:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_writedatamask;
   logic [31:0] mem_readdata;
   logic [1:0]  mem_readdataid;
`ifdef YARI_ARB_PERF_EN
   logic [31:0] perf_arb_imem_blocked;
   logic [31:0] perf_arb_dmem_blocked;
   logic [31:0] perf_arb_outstanding_full;
`endif

   int checks_total  = 0;
   int checks_passed = 0;

   yari_mem_arbiter dut (
      .clock              (clock),
      .rst_n              (rst_n),
      .dmem_waitrequest   (dmem_waitrequest),
      .dmem_address       (dmem_address),
      .dmem_read          (dmem_read),
      .dmem_write         (dmem_write),
      .dmem_writedata     (dmem_writedata),
      .dmem_writedatamask (dmem_writedatamask),
      .dmem_readdata      (dmem_readdata),
      .dmem_readdatavalid (dmem_readdatavalid),
      .imem_waitrequest   (imem_waitrequest),
      .imem_address       (imem_address),
      .imem_read          (imem_read),
      .imem_readdata      (imem_readdata),
      .imem_readdatavalid (imem_readdatavalid),
      .mem_waitrequest    (mem_waitrequest),
      .mem_id             (mem_id),
      .mem_address        (mem_address),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .mem_writedata      (mem_writedata),
      .mem_writedatamask  (mem_writedatamask),
      .mem_readdata       (mem_readdata),
      .mem_readdataid     (mem_readdataid)
`ifdef YARI_ARB_PERF_EN
      ,
      .perf_arb_imem_blocked     (perf_arb_imem_blocked),
      .perf_arb_dmem_blocked     (perf_arb_dmem_blocked),
      .perf_arb_outstanding_full (perf_arb_outstanding_full)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end else begin
         checks_passed++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      dmem_read       = 1'b0;
      dmem_write      = 1'b0;
      imem_read       = 1'b0;
      mem_waitrequest = 1'b0;
      mem_readdataid  = 2'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n              = 1'b0;
      dmem_address       = 30'h0;
      dmem_writedata     = 32'h0;
      dmem_writedatamask = 4'h0;
      imem_address       = 30'h0;
      mem_readdata       = 32'h0;
      idle_inputs();
      dmem_read      = 1'b1;
      imem_read      = 1'b1;
      mem_readdataid = 2'd1;
      #12;
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_dwait", dmem_waitrequest, 1'b1);
      check("rst_iwait", imem_waitrequest, 1'b1);
      check("rst_dvalid", dmem_readdatavalid, 1'b0);
      check("rst_ivalid", imem_readdatavalid, 1'b0);

      tick();
      rst_n = 1'b1;
      idle_inputs();
      #1;
      check("idle_id", mem_id, 2'd2);
      check("idle_read", mem_read, 1'b0);
      check("idle_dwait", dmem_waitrequest, 1'b1);

      // response routing
      mem_readdata   = 32'hDEADBEEF;
      mem_readdataid = 2'd1;
      #1;
      check("route1_dvalid", dmem_readdatavalid, 1'b1);
      check("route1_ivalid", imem_readdatavalid, 1'b0);
      check("route1_ddata", dmem_readdata, 32'hDEADBEEF);
      check("route1_idata", imem_readdata, 32'hDEADBEEF);
      mem_readdataid = 2'd0;
      #1;
      check("route0_dvalid", dmem_readdatavalid, 1'b0);
      check("route0_ivalid", imem_readdatavalid, 1'b0);
      mem_readdataid = 2'd3;
      #1;
      check("route3_dvalid", dmem_readdatavalid, 1'b0);
      check("route3_ivalid", imem_readdatavalid, 1'b0);
      mem_readdataid = 2'd2;
      #1;
      check("route2_ivalid", imem_readdatavalid, 1'b1);
      mem_readdataid = 2'd0;

      // concurrent requests: dmem priority until starvation guard fires
      tick();
      dmem_read      = 1'b1;
      dmem_address   = 30'h100;
      imem_read      = 1'b1;
      imem_address   = 30'h200;
      mem_readdataid = 2'd1;
      for (int c = 1; c <= 16; c++) begin
         #1;
         check($sformatf("conc_id_c%0d", c), mem_id, 2'd1);
         check($sformatf("conc_iwait_c%0d", c), imem_waitrequest, 1'b1);
         tick();
      end
      #1;
      check("starve_id", mem_id, 2'd2);
      check("starve_addr", mem_address, 30'h200);
      check("starve_iwait", imem_waitrequest, 1'b0);
      check("starve_dwait", dmem_waitrequest, 1'b1);
      tick();
      #1;
      check("starve_clear_id", mem_id, 2'd1);
      check("starve_clear_addr", mem_address, 30'h100);
      tick();
      idle_inputs();
      mem_readdataid = 2'd2;
      tick();
      mem_readdataid = 2'd0;

      // grant lock on a stalled imem request
      tick();
      imem_read       = 1'b1;
      imem_address    = 30'h300;
      mem_waitrequest = 1'b1;
      #1;
      check("lock_c1_id", mem_id, 2'd2);
      check("lock_c1_read", mem_read, 1'b1);
      check("lock_c1_iwait", imem_waitrequest, 1'b1);
      tick();
      dmem_write         = 1'b1;
      dmem_address       = 30'h40;
      dmem_writedata     = 32'hCAFEF00D;
      dmem_writedatamask = 4'b0101;
      #1;
      check("lock_c2_id", mem_id, 2'd2);
      check("lock_c2_addr", mem_address, 30'h300);
      check("lock_c2_write", mem_write, 1'b0);
      check("lock_c2_dwait", dmem_waitrequest, 1'b1);
      tick();
      #1;
      check("lock_c3_id", mem_id, 2'd2);
      check("lock_c3_dwait", dmem_waitrequest, 1'b1);
      tick();
      mem_waitrequest = 1'b0;
      #1;
      check("lock_acc_iwait", imem_waitrequest, 1'b0);
      check("lock_acc_dwait", dmem_waitrequest, 1'b1);
      check("lock_acc_id", mem_id, 2'd2);
      tick();
      imem_read = 1'b0;
      #1;
      check("wr_write", mem_write, 1'b1);
      check("wr_read", mem_read, 1'b0);
      check("wr_id", mem_id, 2'd1);
      check("wr_addr", mem_address, 30'h40);
      check("wr_data", mem_writedata, 32'hCAFEF00D);
      check("wr_mask", mem_writedatamask, 4'b0101);
      check("wr_dwait", dmem_waitrequest, 1'b0);
      tick();
      dmem_write     = 1'b0;
      mem_readdataid = 2'd2;
      #1;
      check("drain_ivalid", imem_readdatavalid, 1'b1);
      tick();
      mem_readdataid = 2'd0;

      // writes never consume outstanding slots
      dmem_write = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         #1;
         check($sformatf("wrcnt_dwait_c%0d", c), dmem_waitrequest, 1'b0);
         tick();
      end
      dmem_write = 1'b0;
      dmem_read  = 1'b1;
      #1;
      check("wrcnt_read_dwait", dmem_waitrequest, 1'b0);
      check("wrcnt_read", mem_read, 1'b1);
      tick();
      dmem_read      = 1'b0;
      mem_readdataid = 2'd1;
      tick();
      mem_readdataid = 2'd0;

      // outstanding limit on imem
      imem_read    = 1'b1;
      imem_address = 30'h500;
      for (int c = 1; c <= 4; c++) begin
         #1;
         check($sformatf("out_iwait_c%0d", c), imem_waitrequest, 1'b0);
         tick();
      end
      #1;
      check("out_full_iwait", imem_waitrequest, 1'b1);
      check("out_full_read", mem_read, 1'b0);
      check("out_full_id", mem_id, 2'd2);
      tick();
      mem_readdataid = 2'd2;
      #1;
      check("out_unblock_iwait", imem_waitrequest, 1'b0);
      check("out_unblock_read", mem_read, 1'b1);
      check("out_unblock_ivalid", imem_readdatavalid, 1'b1);
      tick();
      mem_readdataid = 2'd0;
      dmem_read      = 1'b1;
      dmem_address   = 30'h550;
      #1;
      check("out_refull_iwait", imem_waitrequest, 1'b1);
      check("out_dmem_dwait", dmem_waitrequest, 1'b0);
      check("out_dmem_id", mem_id, 2'd1);

      // reset asserted while dmem is locked
      tick();
      imem_read       = 1'b0;
      dmem_address    = 30'h600;
      mem_waitrequest = 1'b1;
      #1;
      check("rlock_c1_id", mem_id, 2'd1);
      tick();
      #1;
      check("rlock_c2_read", mem_read, 1'b1);
      check("rlock_c2_dwait", dmem_waitrequest, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rlock_rst_read", mem_read, 1'b0);
      check("rlock_rst_write", mem_write, 1'b0);
      check("rlock_rst_dwait", dmem_waitrequest, 1'b1);
      check("rlock_rst_iwait", imem_waitrequest, 1'b1);
      tick();
      rst_n           = 1'b1;
      dmem_read       = 1'b0;
      imem_read       = 1'b1;
      imem_address    = 30'h700;
      mem_waitrequest = 1'b0;
      #1;
      check("rlock_post_read", mem_read, 1'b1);
      check("rlock_post_id", mem_id, 2'd2);
      check("rlock_post_addr", mem_address, 30'h700);
      check("rlock_post_iwait", imem_waitrequest, 1'b0);
      tick();

      // extra responses at zero must not underflow the counter
      imem_read      = 1'b0;
      mem_readdataid = 2'd2;
      repeat (3) tick();
      mem_readdataid = 2'd0;
      imem_read      = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         check($sformatf("uflow_iwait_c%0d", c), imem_waitrequest, 1'b0);
         tick();
      end
      #1;
      check("uflow_full_iwait", imem_waitrequest, 1'b1);
      tick();
      idle_inputs();
      mem_readdataid = 2'd2;
      repeat (4) tick();
      mem_readdataid = 2'd0;

`ifdef YARI_ARB_PERF_EN
      rst_n = 1'b0;
      tick();
      rst_n          = 1'b1;
      dmem_read      = 1'b1;
      imem_read      = 1'b1;
      mem_readdataid = 2'd1;
      repeat (10) tick();
      idle_inputs();
      #1;
      check("perf_imem_blocked", perf_arb_imem_blocked, 32'd10);
      check("perf_dmem_blocked", perf_arb_dmem_blocked, 32'd0);
      check("perf_out_full", perf_arb_outstanding_full, 32'd0);
`endif

      tick();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/yari_mem_arbiter.md
Name: yari_mem_arbiter

Overview:
- Shares the single external memory port between the data-cache port (dmem, read/write) and the instruction-cache port (imem, read-only).
- Sits in the yari top level between stage_M/stage_I and the mem_* bus.
- Keeps dmem priority, with three additions:
  - grant locking while a request is stalled;
  - a starvation guard for imem;
  - per-requester outstanding-read limiting with tagged response routing.

Parameters:
- ID_DC, 2'd1, mem_id tag for dmem transactions
- ID_IC, 2'd2, mem_id tag for imem transactions
- STARVE_LIMIT, 16, consecutive imem-blocked cycles after which imem wins arbitration (1..255)
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered reads per requester (1..15)

Ports:
- clock  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dmem_waitrequest  out  1  dmem request not accepted this cycle
- dmem_address  in  30  word address
- dmem_read  in  1  read strobe
- dmem_write  in  1  write strobe
- dmem_writedata  in  32  write data
- dmem_writedatamask  in  4  byte enables
- dmem_readdata  out  32  read data
- dmem_readdatavalid  out  1  response for dmem
- imem_waitrequest  out  1  imem request not accepted this cycle
- imem_address  in  30  word address
- imem_read  in  1  read strobe
- imem_readdata  out  32  read data
- imem_readdatavalid  out  1  response for imem
- mem_waitrequest  in  1  memory stall
- mem_id  out  2  transaction tag
- mem_address  out  30  muxed address
- mem_read  out  1  muxed read
- mem_write  out  1  dmem write only
- mem_writedata  out  32  dmem write data
- mem_writedatamask  out  4  dmem byte enables
- mem_readdata  in  32  response data
- mem_readdataid  in  2  response tag

Behaviour:
- Reset: clock and asynchronous active-low reset as stated in the port list (clock, rst_n).
  - While rst_n=0: state=IDLE, starve_cnt=0, both outstanding counters=0.
  - mem_read=mem_write=0; both *_waitrequest=1; both *_readdatavalid=0.
- Eligibility:
  - d_eligible = (dmem_read & d_out<MAX_OUTSTANDING) | dmem_write.
  - i_eligible = imem_read & i_out<MAX_OUTSTANDING.
- FSM states: IDLE, LOCK_D, LOCK_I.
- Owner selection:
  - LOCK_D forces owner=dmem; LOCK_I forces owner=imem.
  - In IDLE: imem wins if i_eligible & (starve_cnt==STARVE_LIMIT | ~d_eligible); otherwise dmem wins if d_eligible; otherwise no owner.
- Owner-driven outputs:
  - mem_read, mem_write, mem_address and mem_id follow the owner; mem_id=ID_IC when there is no owner.
  - mem_writedata and mask always come from dmem.
  - Owner waitrequest = mem_waitrequest; non-owner waitrequest = 1.
- Transitions:
  - Owner strobing & mem_waitrequest=1 -> LOCK_<owner> next cycle. Requester must hold its request stable.
  - Owner accepted (mem_waitrequest=0) -> IDLE. Zero-cycle arbitration: back-to-back accepts are possible every cycle.
  - Owner drops its strobe while locked -> IDLE (protocol violation; tolerated).
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle imem_read=1 and imem is not accepted.
  - Clears on imem accept or when imem_read=0.
- Outstanding counters:
  - Increment on an accepted read of that requester; decrement when mem_readdataid matches that requester's ID.
  - Increment and decrement in the same cycle -> unchanged.
  - Decrement at 0 -> stays 0.
  - A read blocked at the limit sees waitrequest=1 and is not forwarded.
  - Writes are never counted.
- Response routing (combinational):
  - dmem_readdatavalid = (mem_readdataid==ID_DC); imem_readdatavalid = (mem_readdataid==ID_IC).
  - Any other tag is dropped.
  - Readdata is fanned out to both requesters.
- Simultaneous dmem read+write: not legal; write takes mem_write, read is ignored.

Optional Feature:
- Macro: YARI_ARB_PERF_EN.
- When defined, adds the following outputs, each counting up from 0 at reset and wrapping at 2^32:
  - perf_arb_imem_blocked [31:0]: cycles imem_read=1 and not owner.
  - perf_arb_dmem_blocked [31:0]: cycles dmem strobe=1 and not owner.
  - perf_arb_outstanding_full [31:0]: cycles either counter is at MAX_OUTSTANDING while its read strobe is high.
- When undefined: ports absent, no counter logic.

Test Plan:
- Concurrent requests: dmem_read and imem_read both high, mem_waitrequest=0, STARVE_LIMIT=16 -> dmem accepted every cycle, mem_id=1. On cycle 17 imem is accepted with mem_id=2 and starve_cnt clears.
- Grant lock: imem owner with mem_waitrequest=1 for 3 cycles, dmem_write asserted in cycle 2 -> imem stays owner, dmem_waitrequest=1. After imem accepts, dmem write issues next cycle.
- Outstanding limit: issue 4 accepted imem reads with no response, then a 5th -> 5th sees imem_waitrequest=1 and mem_read=0. A response with mem_readdataid=2 unblocks it in the same cycle.
- Response routing: mem_readdataid=1 with data 0xDEADBEEF -> dmem_readdatavalid=1, imem_readdatavalid=0. Tag 0 or 3 -> both valid=0.
- Reset mid-lock: rst_n pulled low while in LOCK_D -> outputs go to reset values immediately. After release, state=IDLE and counters=0.
- Perf (YARI_ARB_PERF_EN): 10 cycles of dmem-vs-imem contention with STARVE_LIMIT=16 -> perf_arb_imem_blocked=10.
